// File: rtl/decode_fifo_if.sv
// Fetch/execute handshake bundle for decode_fifo: fetch pushes {inst, pc}, execute pops {inst, pc, ctrl}.
// master = the fetch/execute side that drives in_* and out_ready; slave = the buffer itself.
interface decode_fifo_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_pc;
  logic [11:0]     out_ctrl;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_ctrl
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_ctrl
  );
endinterface

// File: rtl/decode_fifo.sv
// Decode buffer between fetch and execute: decodes at enqueue, stores {inst, pc, ctrl} in a DEPTH-entry FIFO.
// Define CP0_DEC_EN to decode MTC0/MFC0/ERET; otherwise every COP0 encoding is flagged invalid.
module decode_fifo #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  decode_fifo_if.slave           bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [5:0] EXE_SPECIAL = 6'b000000, EXE_REGIMM = 6'b000001,
                         EXE_J       = 6'b000010, EXE_JAL    = 6'b000011,
                         EXE_BEQ     = 6'b000100, EXE_BNE    = 6'b000101,
                         EXE_BLEZ    = 6'b000110, EXE_BGTZ   = 6'b000111,
                         EXE_ADDI    = 6'b001000, EXE_ADDIU  = 6'b001001,
                         EXE_SLTI    = 6'b001010, EXE_SLTIU  = 6'b001011,
                         EXE_ANDI    = 6'b001100, EXE_ORI    = 6'b001101,
                         EXE_XORI    = 6'b001110, EXE_LUI    = 6'b001111,
                         EXE_COP0    = 6'b010000,
                         EXE_LB      = 6'b100000, EXE_LH     = 6'b100001,
                         EXE_LW      = 6'b100011, EXE_LBU    = 6'b100100,
                         EXE_LHU     = 6'b100101, EXE_SB     = 6'b101000,
                         EXE_SH      = 6'b101001, EXE_SW     = 6'b101011;

  localparam logic [11:0] C_RW = 12'h001, C_RDST = 12'h002, C_ASRC = 12'h004,
                          C_BR = 12'h008, C_MEN  = 12'h010, C_MWR  = 12'h020,
                          C_M2R = 12'h040, C_J   = 12'h080, C_JR   = 12'h100,
                          C_AL = 12'h200, C_INV  = 12'h400, C_CP0W = 12'h800;

  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [11:0]     ctrl_mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            push, pop;
  logic [11:0]     dec_ctrl;
  logic [5:0]      op, funct;
  logic [4:0]      rs, rt;

  assign op    = bus.in_inst[31:26];
  assign rs    = bus.in_inst[25:21];
  assign rt    = bus.in_inst[20:16];
  assign funct = bus.in_inst[5:0];

  // Every invalid outcome assigns C_INV outright so it never carries other bits.
  always_comb begin
    dec_ctrl = '0;
    case (op)
      EXE_SPECIAL: begin
        case (funct)
          6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
          6'b010000, 6'b010010, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
          6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010, 6'b101011:
            dec_ctrl = C_RW | C_RDST;
          6'b001001: dec_ctrl = C_RW | C_RDST | C_JR;
          6'b001000: dec_ctrl = C_JR;
          6'b010001, 6'b010011, 6'b001100, 6'b001101: dec_ctrl = '0;
          default:   dec_ctrl = C_INV;
        endcase
      end
      EXE_ANDI, EXE_ORI, EXE_XORI, EXE_LUI,
      EXE_ADDI, EXE_ADDIU, EXE_SLTI, EXE_SLTIU:
        dec_ctrl = C_RW | C_ASRC;
      EXE_BEQ, EXE_BNE, EXE_BGTZ, EXE_BLEZ:
        dec_ctrl = C_BR;
      EXE_REGIMM: begin
        case (rt)
          5'b00000, 5'b00001: dec_ctrl = C_BR;
          5'b10000, 5'b10001: dec_ctrl = C_RW | C_BR | C_AL;
          default:            dec_ctrl = C_INV;
        endcase
      end
      EXE_J:   dec_ctrl = C_J;
      EXE_JAL: dec_ctrl = C_RW | C_J | C_AL;
      EXE_LB, EXE_LBU, EXE_LH, EXE_LHU, EXE_LW:
        dec_ctrl = C_RW | C_ASRC | C_MEN | C_M2R;
      EXE_SB, EXE_SH, EXE_SW:
        dec_ctrl = C_ASRC | C_MEN | C_MWR;
`ifdef CP0_DEC_EN
      EXE_COP0: begin
        if (rs == 5'b00100)                          dec_ctrl = C_CP0W;
        else if (rs == 5'b00000)                     dec_ctrl = C_RW;
        else if (rs == 5'b10000 && funct == 6'b011000) dec_ctrl = '0;
        else                                         dec_ctrl = C_INV;
      end
`else
      EXE_COP0: dec_ctrl = C_INV;
`endif
      default: dec_ctrl = C_INV;
    endcase
  end

  // Handshake flags come straight from the occupancy register.
  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push = bus.in_valid && bus.in_ready && !flush;
  assign pop  = bus.out_valid && bus.out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= bus.in_inst;
      pc_mem[wr_ptr]   <= bus.in_pc;
      ctrl_mem[wr_ptr] <= dec_ctrl;
    end
  end

  assign bus.out_inst = bus.out_valid ? inst_mem[rd_ptr] : '0;
  assign bus.out_pc   = bus.out_valid ? pc_mem[rd_ptr]   : '0;
  assign bus.out_ctrl = bus.out_valid ? ctrl_mem[rd_ptr] : '0;
endmodule
